// File: rtl/generador_sensores.sv
// generador_sensores: plays one timed A/B quadrature vehicle pass (entry or exit) for entrada_salida.
// Optional contact-bounce modelling is enabled by defining GENERADOR_REBOTE_EN.
module generador_sensores #(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic [2:0] fase,
  output logic [7:0] pasadas
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    F1   = 3'b001,
    F2   = 3'b010,
    F3   = 3'b011,
    GAP  = 3'b100
  } estado_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  estado_t       estado;
  logic          dir_q;
  logic [CW-1:0] timer;
  logic          fin_fase;

  // AB value held during a phase; exit mirrors entry so the sequence stays Gray-coded
  function automatic logic [1:0] ab_de(input estado_t e, input logic d);
    case (e)
      F1:      ab_de = d ? 2'b01 : 2'b10;
      F2:      ab_de = 2'b11;
      F3:      ab_de = d ? 2'b10 : 2'b01;
      default: ab_de = 2'b00;
    endcase
  endfunction

  function automatic estado_t siguiente(input estado_t e);
    case (e)
      IDLE:    siguiente = F1;
      F1:      siguiente = F2;
      F2:      siguiente = F3;
      F3:      siguiente = GAP;
      default: siguiente = IDLE;
    endcase
  endfunction

`ifdef GENERADOR_REBOTE_EN
  function automatic estado_t anterior(input estado_t e);
    case (e)
      F2:      anterior = F1;
      F3:      anterior = F2;
      GAP:     anterior = F3;
      default: anterior = IDLE;
    endcase
  endfunction
`endif

  assign fin_fase = (estado == GAP) ? (timer == GAP_LAST) : (timer == HOLD_LAST);
  assign fase     = estado;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado  <= IDLE;
      dir_q   <= 1'b0;
      timer   <= '0;
      A       <= 1'b0;
      B       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pasadas <= '0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (start && !abort) begin
            estado <= F1;
            dir_q  <= dir;
            timer  <= '0;
            {A, B} <= ab_de(F1, dir);
            busy   <= 1'b1;
          end
        end
        F1, F2, F3, GAP: begin
          if (abort) begin
            estado <= IDLE;
            timer  <= '0;
            {A, B} <= 2'b00;
            busy   <= 1'b0;
          end else if (fin_fase) begin
            estado <= siguiente(estado);
            timer  <= '0;
            {A, B} <= ab_de(siguiente(estado), dir_q);
            busy   <= (estado != GAP);
            if (estado == GAP) begin
              done    <= 1'b1;
              pasadas <= pasadas + 8'd1;
            end
          end else begin
            timer <= timer + CW'(1);
`ifdef GENERADOR_REBOTE_EN
            // second cycle of a phase reverts the toggled bit, then it settles again
            if (HOLD_CYCLES >= 3 && timer == '0)
              {A, B} <= ab_de(anterior(estado), dir_q);
            else
              {A, B} <= ab_de(estado, dir_q);
`endif
          end
        end
        default: begin
          estado <= IDLE;
          timer  <= '0;
          {A, B} <= 2'b00;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_sensores.sv
// Scoreboard bench for generador_sensores: expected outputs queued per driven cycle, compared on negedge.
module tb_generador_sensores;

  localparam int unsigned HOLD = 5;
  localparam int unsigned GAP  = 2;

  logic       clk = 1'b0;
  logic       reset, start, dir, abort;
  logic       A, B, busy, done;
  logic [2:0] fase;
  logic [7:0] pasadas;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [2:0] fase;
    logic [7:0] pas;
  } esperado_t;

  esperado_t  cola[$];
  int         checks  = 0;
  int         errores = 0;
  logic [7:0] pcount;

  generador_sensores #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
    .A(A), .B(B), .busy(busy), .done(done), .fase(fase), .pasadas(pasadas)
  );

  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic esperado_t mk(input logic a, input logic b, input logic bs, input logic dn,
                                   input logic [2:0] f, input logic [7:0] p);
    mk = '{a, b, bs, dn, f, p};
  endfunction

  // reference AB per phase index: 0..2 = F1..F3, 3 = gap
  function automatic logic [1:0] ab_esp(input logic d, input int ph);
    case (ph)
      0:       ab_esp = d ? 2'b01 : 2'b10;
      1:       ab_esp = 2'b11;
      2:       ab_esp = d ? 2'b10 : 2'b01;
      default: ab_esp = 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cola.size() > 0) begin
      esperado_t e;
      e = cola.pop_front();
      comprobar("ciclo", 32'({A, B, busy, done, fase, pasadas}), 32'(e));
    end
  end

  task automatic tick(input esperado_t e);
    cola.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_pass(input logic d, input bit molestar, input int abort_at, input int reset_at);
    for (int i = 0; i < int'(3 * HOLD + GAP); i++) begin
      int         ph;
      int         idx;
      logic [1:0] ab;
      if (i == reset_at) begin
        reset = 1'b1;
        #1;
        comprobar("reset_async", 32'({A, B, busy, done, fase, pasadas}), 32'(0));
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        pcount = 8'd0;
        #1;
        return;
      end
      ph  = (i < int'(3 * HOLD)) ? i / int'(HOLD) : 3;
      idx = (i < int'(3 * HOLD)) ? i % int'(HOLD) : i - int'(3 * HOLD);
      ab  = ab_esp(d, ph);
`ifdef GENERADOR_REBOTE_EN
      if (idx == 1) ab = (ph == 0) ? 2'b00 : ab_esp(d, ph - 1);
`endif
      start = (i == 0) || (molestar && i == 7);
      dir   = (i == 0) ? d : (molestar ? ~dir : dir);
      abort = (i == abort_at);
      if (i == abort_at) begin
        tick(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, pcount));
        abort = 1'b0;
        start = 1'b0;
        return;
      end
      tick(mk(ab[1], ab[0], 1'b1, 1'b0, 3'(ph + 1), pcount));
      if (idx < 0) comprobar("indice", 32'(idx), 32'(0));
    end
    start  = 1'b0;
    pcount = pcount + 8'd1;
    tick(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, pcount));
    tick(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, pcount));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    dir    = 1'b0;
    abort  = 1'b0;
    pcount = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    comprobar("reset_vals", 32'({A, B, busy, done, fase, pasadas}), 32'(0));
    #1;
    reset = 1'b0;
    tick(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));

    run_pass(1'b0, 1'b0, -1, -1);
    comprobar("pasadas_1", 32'(pasadas), 32'(1));
    run_pass(1'b1, 1'b0, -1, -1);
    comprobar("pasadas_2", 32'(pasadas), 32'(2));
    run_pass(1'b0, 1'b1, -1, -1);
    run_pass(1'b1, 1'b0, 12, -1);
    comprobar("abort_pasadas", 32'(pasadas), 32'(3));

    start = 1'b1;
    abort = 1'b1;
    tick(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, pcount));
    start = 1'b0;
    abort = 1'b0;
    tick(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, pcount));

    run_pass(1'b0, 1'b0, -1, 8);
    for (int k = 0; k < 256; k++) run_pass(k[0], 1'b0, -1, -1);
    comprobar("wrap", 32'(pasadas), 32'(0));
    comprobar("cola_vacia", 32'(cola.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errores);
    $finish;
  end

endmodule
